instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_perf_counter.sv | 25 ++
 rtl/instruction_fetch.sv | 92 +++++++++
 tb/tb_instruction_fetch.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PcW    = 64;
  localparam int unsigned InstrW = 32;

  localparam logic [PcW-1:0] DefResetPc = 64'h0;
  localparam int unsigned    DefPcStep  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// Free-running wrapping event counter with synchronous active-high reset.
module fetch_perf_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage with decode handshake and branch redirect.
// Define FETCH_PERF_CNT_EN to add the fetch_count output.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [PcW-1:0] RESET_PC = DefResetPc,
  parameter int unsigned    PC_STEP  = DefPcStep
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PcW-1:0]    pc,
  output logic [PcW-1:0]    next_pc,
  output logic              imem_req,
  output logic [PcW-1:0]    imem_addr,
  input  logic              imem_ack,
  input  logic [InstrW-1:0] imem_rdata,
  output logic [InstrW-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [PcW-1:0]    branch_target
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [InstrW-1:0] instr_q, instr_d;
  logic              accept;
  logic [PcW-1:0]    target_aligned;

  assign target_aligned = branch_target & ~64'h3;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    accept   = 1'b0;
    imem_req = 1'b0;
    next_pc  = pc;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_ready) begin
          accept  = 1'b1;
          state_d = StReq;
          next_pc = branch_taken ? target_aligned : pc + 64'(PC_STEP);
        end
      end
      default: state_d = StIdle;
    endcase
    // Reset overrides the outputs in the same cycle so the PC register loads RESET_PC.
    if (rst) begin
      imem_req = 1'b0;
      accept   = 1'b0;
      next_pc  = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_valid = (state_q == StHold);

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter #(
    .Width(32)
  ) u_perf_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .count(fetch_count)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch; one vector per clock cycle.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic [63:0] next_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [63:0] branch_target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .next_pc      (next_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [63:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        bt;
    logic [63:0] btgt;
    logic        e_req;
    logic [63:0] e_npc;
    logic        cv;
    logic        e_vld;
    logic        ci;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic [63:0] p, logic a, logic [31:0] d, logic rd,
                              logic b, logic [63:0] bg, logic er, logic [63:0] en,
                              logic cv, logic ev, logic ci, logic [31:0] ei);
    vec_t t;
    t.rst = r; t.pc = p; t.ack = a; t.rdata = d; t.rdy = rd; t.bt = b; t.btgt = bg;
    t.e_req = er; t.e_npc = en; t.cv = cv; t.e_vld = ev; t.ci = ci; t.e_instr = ei;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [63:0] p, input logic a, input logic [31:0] d,
                       input logic rd, input logic b, input logic [63:0] bg);
    rst = r; pc = p; imem_ack = a; imem_rdata = d; instr_ready = rd;
    branch_taken = b; branch_target = bg;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] p;

  initial begin
    drive(1'b1, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();

    //      rst pc                     ack rdata         rdy bt btgt      req npc                    cv vld ci instr
    tv.push_back(mk(1, 64'h0,                0, 32'h0,        0, 0, 64'h0,   0, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(1, 64'h0,                1, 32'hDEADBEEF, 1, 1, 64'h200, 0, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(0, 64'h0,                1, 32'hDEADBEEF, 0, 0, 64'h0,   0, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(0, 64'h0,                1, 32'h00A00093, 1, 0, 64'h0,   1, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(0, 64'h0,                0, 32'h0,        1, 0, 64'h0,   0, 64'h4,               1, 1, 1, 32'h00A00093));
    tv.push_back(mk(0, 64'h4,                0, 32'h0,        0, 1, 64'h500, 1, 64'h4,               1, 0, 0, 32'h0));
    tv.push_back(mk(0, 64'h4,                0, 32'h0,        1, 1, 64'h500, 1, 64'h4,               1, 0, 0, 32'h0));
    tv.push_back(mk(0, 64'h4,                0, 32'h0,        0, 0, 64'h0,   1, 64'h4,               1, 0, 0, 32'h0));
    tv.push_back(mk(0, 64'h4,                1, 32'h12345678, 0, 0, 64'h0,   1, 64'h4,               1, 0, 0, 32'h0));
    tv.push_back(mk(0, 64'h4,                1, 32'hFFFFFFFF, 0, 0, 64'h0,   0, 64'h4,               1, 1, 1, 32'h12345678));
    tv.push_back(mk(0, 64'h4,                0, 32'h0,        0, 1, 64'h103, 0, 64'h4,               1, 1, 1, 32'h12345678));
    tv.push_back(mk(0, 64'h4,                1, 32'h0BADF00D, 0, 0, 64'h0,   0, 64'h4,               1, 1, 1, 32'h12345678));
    tv.push_back(mk(0, 64'h4,                0, 32'h0,        0, 1, 64'h103, 0, 64'h4,               1, 1, 1, 32'h12345678));
    tv.push_back(mk(0, 64'h4,                0, 32'h0,        1, 1, 64'h103, 0, 64'h100,             1, 1, 1, 32'h12345678));
    tv.push_back(mk(0, 64'h100,              1, 32'hCAFEF00D, 0, 0, 64'h0,   1, 64'h100,             1, 0, 0, 32'h0));
    tv.push_back(mk(0, 64'h100,              0, 32'h0,        1, 0, 64'h0,   0, 64'h104,             1, 1, 1, 32'hCAFEF00D));
    tv.push_back(mk(0, 64'hFFFFFFFFFFFFFFFC, 1, 32'h11111111, 0, 1, 64'h800, 1, 64'hFFFFFFFFFFFFFFFC, 1, 0, 0, 32'h0));
    tv.push_back(mk(0, 64'hFFFFFFFFFFFFFFFC, 0, 32'h0,        1, 0, 64'h0,   0, 64'h0,               1, 1, 1, 32'h11111111));
    tv.push_back(mk(0, 64'h0,                1, 32'h22222222, 0, 0, 64'h0,   1, 64'h0,               1, 0, 0, 32'h0));
    tv.push_back(mk(0, 64'h0,                0, 32'h0,        0, 0, 64'h0,   0, 64'h0,               1, 1, 1, 32'h22222222));
    tv.push_back(mk(1, 64'h10,               0, 32'h0,        1, 1, 64'h300, 0, 64'h0,               0, 0, 0, 32'h0));
    tv.push_back(mk(1, 64'h10,               1, 32'h44444444, 0, 0, 64'h0,   0, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(0, 64'h0,                0, 32'h0,        0, 0, 64'h0,   0, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(0, 64'h0,                0, 32'h0,        0, 0, 64'h0,   1, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(1, 64'h40,               1, 32'h55555555, 0, 0, 64'h0,   0, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(0, 64'h0,                1, 32'h33333333, 0, 0, 64'h0,   0, 64'h0,               1, 0, 1, 32'h0));
    tv.push_back(mk(0, 64'h0,                0, 32'h0,        0, 0, 64'h0,   1, 64'h0,               1, 0, 1, 32'h0));

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].pc, tv[i].ack, tv[i].rdata, tv[i].rdy, tv[i].bt, tv[i].btgt);
      chk($sformatf("v%0d imem_req", i), 64'(imem_req), 64'(tv[i].e_req));
      chk($sformatf("v%0d imem_addr", i), imem_addr, tv[i].pc);
      chk($sformatf("v%0d next_pc", i), next_pc, tv[i].e_npc);
      if (tv[i].cv) chk($sformatf("v%0d instr_valid", i), 64'(instr_valid), 64'(tv[i].e_vld));
      if (tv[i].ci) chk($sformatf("v%0d instr", i), 64'(instr), 64'(tv[i].e_instr));
      tick();
    end

`ifdef FETCH_PERF_CNT_EN
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("count after reset", 64'(fetch_count), 64'd0);
`endif

    // Five back-to-back fetches with single-cycle ack and immediate accept.
    p = 64'h0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, p, 1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0, 64'h0);
      chk($sformatf("seq%0d imem_req", k), 64'(imem_req), 64'd1);
      tick();
      drive(1'b0, p, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
      chk($sformatf("seq%0d instr_valid", k), 64'(instr_valid), 64'd1);
      chk($sformatf("seq%0d instr", k), 64'(instr), 64'(32'hA0 + 32'(k)));
      chk($sformatf("seq%0d next_pc", k), next_pc, p + 64'd4);
      tick();
      p = p + 64'd4;
    end

`ifdef FETCH_PERF_CNT_EN
    drive(1'b0, p, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("count after 5", 64'(fetch_count), 64'd5);
    drive(1'b1, p, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    chk("count cleared", 64'(fetch_count), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
